// File: rtl/free_list.sv
// Physical register free list: a circular queue of ids with a speculative
// allocation head, a committed head and an insertion tail; flush rewinds to commit.
module free_list #(
    parameter int N_PREG  = 64,
    parameter int N_AREG  = 32,
    parameter int N_ALLOC = 2,
    parameter int N_FREE  = 2,
    localparam int ID_W   = $clog2(N_PREG),
    localparam int DEPTH  = N_PREG - N_AREG,
    localparam int CNT_W  = $clog2(DEPTH + 1),
    localparam int CC_W   = $clog2(N_ALLOC + 1)
) (
    input  logic                           clk,
    input  logic                           resetn,
    input  logic [N_ALLOC-1:0]             alloc_req,
    output logic                           alloc_ready,
    output logic [N_ALLOC-1:0][ID_W-1:0]   alloc_id,
    input  logic [CC_W-1:0]                commit_cnt,
    input  logic [N_FREE-1:0]              free_valid,
    input  logic [N_FREE-1:0][ID_W-1:0]    free_id,
    input  logic                           flush,
    output logic [CNT_W-1:0]               count
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int PTR_W = IDX_W + 1;

    typedef logic [PTR_W-1:0] ptr_t;
    typedef logic [IDX_W-1:0] idx_t;
    typedef logic [ID_W-1:0]  id_t;

    generate
        if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_check
            $error("free_list: N_PREG-N_AREG must be a power of two of at least 2");
        end
    endgenerate

    id_t            entry_q [DEPTH];
    id_t            entry_d [DEPTH];
    ptr_t           head_q, head_d;
    ptr_t           chead_q, chead_d;
    ptr_t           tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;

    ptr_t           n_req;
    logic           alloc_fire;

    assign count       = count_q;
    assign alloc_ready = (count_q >= CNT_W'(N_ALLOC)) && !flush;
    assign alloc_fire  = alloc_ready && (|alloc_req);

    // Requesting lanes are compacted; idle lanes show entry[head+i] so the
    // ids visible with no request pending read out in queue order.
    always_comb begin
        int   k;
        idx_t rd_idx;
        k        = 0;
        rd_idx   = '0;
        alloc_id = '0;
        for (int i = 0; i < N_ALLOC; i++) begin
            if (alloc_req[i]) begin
                rd_idx = head_q[IDX_W-1:0] + idx_t'(k);
                k++;
            end else begin
                rd_idx = head_q[IDX_W-1:0] + idx_t'(i);
            end
            alloc_id[i] = entry_q[rd_idx];
        end
    end

    always_comb begin
        n_req = '0;
        for (int i = 0; i < N_ALLOC; i++) begin
            if (alloc_req[i]) n_req = n_req + ptr_t'(1);
        end
    end

    always_comb begin
        int   k;
        idx_t wr_idx;
        entry_d = entry_q;
        k       = 0;
        wr_idx  = '0;
        for (int j = 0; j < N_FREE; j++) begin
            if (free_valid[j]) begin
                wr_idx          = tail_q[IDX_W-1:0] + idx_t'(k);
                entry_d[wr_idx] = free_id[j];
                k++;
            end
        end
        tail_d  = tail_q + ptr_t'(k);
        chead_d = chead_q + ptr_t'(commit_cnt);

        // Flush rewinds to the committed point including this cycle's commits.
        if (flush) begin
            head_d = chead_d;
        end else if (alloc_fire) begin
            head_d = head_q + n_req;
        end else begin
            head_d = head_q;
        end

        count_d = CNT_W'(tail_d - head_d);
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            for (int k = 0; k < DEPTH; k++) begin
                entry_q[k] <= id_t'(N_AREG + k);
            end
            head_q  <= '0;
            chead_q <= '0;
            tail_q  <= ptr_t'(DEPTH);
            count_q <= CNT_W'(DEPTH);
        end else begin
            entry_q <= entry_d;
            head_q  <= head_d;
            chead_q <= chead_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

`ifndef SYNTHESIS
    ptr_t spec_cnt;
    ptr_t held_cnt;
    assign spec_cnt = head_q - chead_q;
    assign held_cnt = tail_d - chead_d;

    always @(posedge clk) begin
        if (resetn) begin
            assert (ptr_t'(commit_cnt) <= spec_cnt)
                else $error("free_list: commit_cnt %0d exceeds outstanding %0d", commit_cnt, spec_cnt);
            assert (held_cnt <= ptr_t'(DEPTH))
                else $error("free_list: release overfills queue (%0d held)", held_cnt);
        end
    end
`endif

endmodule

// File: tb/tb_free_list.sv
// Scoreboard bench for free_list: directed scenarios plus a long randomised
// alloc/commit/free/flush mix checked against a queue-based reference model.
module tb_free_list;
    localparam int N_PREG  = 64;
    localparam int N_AREG  = 32;
    localparam int N_ALLOC = 2;
    localparam int N_FREE  = 2;
    localparam int DEPTH   = N_PREG - N_AREG;

    logic                      clk = 1'b0;
    logic                      resetn;
    logic [N_ALLOC-1:0]        alloc_req;
    logic                      alloc_ready;
    logic [N_ALLOC-1:0][5:0]   alloc_id;
    logic [1:0]                commit_cnt;
    logic [N_FREE-1:0]         free_valid;
    logic [N_FREE-1:0][5:0]    free_id;
    logic                      flush;
    logic [5:0]                count;

    free_list #(
        .N_PREG (N_PREG),
        .N_AREG (N_AREG),
        .N_ALLOC(N_ALLOC),
        .N_FREE (N_FREE)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .alloc_req  (alloc_req),
        .alloc_ready(alloc_ready),
        .alloc_id   (alloc_id),
        .commit_cnt (commit_cnt),
        .free_valid (free_valid),
        .free_id    (free_id),
        .flush      (flush),
        .count      (count)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int exp_q[$];
    int seen_q[$];
    bit capture = 1'b0;
    int mon_e;

    int m_free[$];
    int m_spec[$];
    int m_live[$];

    // Monitor: every granted lane must match the next expected id.
    always @(negedge clk) begin
        if (resetn === 1'b1 && alloc_ready === 1'b1 && (|alloc_req)) begin
            for (int i = 0; i < N_ALLOC; i++) begin
                if (alloc_req[i]) begin
                    n_tests++;
                    if (capture) seen_q.push_back(int'(alloc_id[i]));
                    if (exp_q.size() == 0) begin
                        n_fail++;
                        $display("FAIL alloc_unexpected lane%0d: got id %0d, none expected", i, alloc_id[i]);
                    end else begin
                        mon_e = exp_q.pop_front();
                        if (int'(alloc_id[i]) != mon_e) begin
                            n_fail++;
                            $display("FAIL alloc_id lane%0d: got %0d expected %0d", i, alloc_id[i], mon_e);
                        end
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic drive(input logic [1:0] req, input logic [1:0] cc, input logic [1:0] fv,
                         input int f0, input int f1, input logic fl);
        alloc_req     = req;
        commit_cnt    = cc;
        free_valid    = fv;
        free_id[0]    = 6'(f0);
        free_id[1]    = 6'(f1);
        flush         = fl;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        drive(2'b00, 2'd0, 2'b00, 0, 0, 1'b0);
        #1;
    endtask

    task automatic do_reset();
        chk("scoreboard_drained", exp_q.size(), 0);
        exp_q.delete();
        resetn = 1'b0;
        drive(2'b00, 2'd0, 2'b00, 0, 0, 1'b0);
        step();
        step();
        resetn = 1'b1;
    endtask

    task automatic run_random(input int cycles);
        logic [1:0] req;
        logic [1:0] fv;
        int cc, nf, maxf, fl, idx, drained;
        int f[2];
        int hits[N_PREG];
        int bad;
        m_free.delete();
        m_spec.delete();
        m_live.delete();
        for (int i = 0; i < DEPTH; i++) m_free.push_back(N_AREG + i);
        for (int i = 0; i < N_AREG; i++) m_live.push_back(i);
        do_reset();
        for (int cyc = 0; cyc < cycles; cyc++) begin
            req  = 2'($urandom_range(0, 3));
            fl   = ($urandom_range(0, 15) == 0) ? 1 : 0;
            cc   = $urandom_range(0, (m_spec.size() < 2) ? m_spec.size() : 2);
            maxf = m_live.size() + cc - N_AREG;
            if (maxf > 2) maxf = 2;
            nf   = (maxf > 0) ? $urandom_range(0, maxf) : 0;
            fv   = 2'b00;
            f[0] = 0;
            f[1] = 0;
            for (int j = 0; j < nf; j++) begin
                idx   = $urandom_range(0, m_live.size() - 1);
                f[j]  = m_live[idx];
                m_live.delete(idx);
                fv[j] = 1'b1;
            end
            if (nf == 1 && $urandom_range(0, 1) == 1) begin
                fv   = 2'b10;
                f[1] = f[0];
            end
            for (int j = 0; j < cc; j++) m_live.push_back(m_spec.pop_front());
            if (fl == 0 && m_free.size() >= N_ALLOC && req != 2'b00) begin
                for (int i = 0; i < N_ALLOC; i++) begin
                    if (req[i]) begin
                        idx = m_free.pop_front();
                        exp_q.push_back(idx);
                        m_spec.push_back(idx);
                    end
                end
            end
            if (fl != 0) begin
                while (m_spec.size() > 0) m_free.push_front(m_spec.pop_back());
            end
            for (int j = 0; j < N_FREE; j++) if (fv[j]) m_free.push_back(f[j]);
            drive(req, 2'(cc), fv, f[0], f[1], fl[0]);
            step();
            chk("rnd_count", int'(count), m_free.size());
            chk("rnd_count_in_range", (int'(count) <= DEPTH) ? 1 : 0, 1);
        end
        // Rewind all speculation, then drain the queue to audit id conservation.
        drive(2'b00, 2'd0, 2'b00, 0, 0, 1'b1);
        while (m_spec.size() > 0) m_free.push_front(m_spec.pop_back());
        step();
        idle();
        chk("rnd_flush_count", int'(count), m_free.size());
        seen_q.delete();
        capture = 1'b1;
        drained = 0;
        while (m_free.size() >= N_ALLOC) begin
            for (int i = 0; i < N_ALLOC; i++) begin
                idx = m_free.pop_front();
                exp_q.push_back(idx);
                m_spec.push_back(idx);
            end
            drained += N_ALLOC;
            drive(2'b11, 2'd0, 2'b00, 0, 0, 1'b0);
            step();
        end
        idle();
        capture = 1'b0;
        chk("drain_size", seen_q.size(), drained);
        for (int i = 0; i < N_PREG; i++) hits[i] = 0;
        foreach (seen_q[i]) hits[seen_q[i]]++;
        foreach (m_live[i]) hits[m_live[i]]++;
        foreach (m_free[i]) hits[m_free[i]]++;
        bad = 0;
        for (int i = 0; i < N_PREG; i++) if (hits[i] != 1) bad++;
        chk("id_conservation_bad_ids", bad, 0);
    endtask

    initial begin
        resetn = 1'b0;
        drive(2'b00, 2'd0, 2'b00, 0, 0, 1'b0);

        // Reset state and dual-lane allocation.
        do_reset();
        #1;
        chk("rst_count", int'(count), 32);
        chk("rst_ready", int'(alloc_ready), 1);
        chk("rst_id0", int'(alloc_id[0]), 32);
        chk("rst_id1", int'(alloc_id[1]), 33);
        drive(2'b11, 2'd0, 2'b00, 0, 0, 1'b0);
        exp_q.push_back(32);
        exp_q.push_back(33);
        #1;
        chk("t1_ready", int'(alloc_ready), 1);
        step();
        idle();
        chk("t1_count", int'(count), 30);
        chk("t1_next_id0", int'(alloc_id[0]), 34);

        // Lane compaction.
        do_reset();
        drive(2'b10, 2'd0, 2'b00, 0, 0, 1'b0);
        exp_q.push_back(32);
        step();
        drive(2'b01, 2'd0, 2'b00, 0, 0, 1'b0);
        exp_q.push_back(33);
        step();
        idle();
        chk("t2_count", int'(count), 30);

        // Near-empty threshold, release, and empty.
        do_reset();
        for (int c = 0; c < 15; c++) begin
            drive(2'b11, 2'd0, 2'b00, 0, 0, 1'b0);
            exp_q.push_back(32 + 2 * c);
            exp_q.push_back(33 + 2 * c);
            step();
        end
        idle();
        chk("t3_count2", int'(count), 2);
        chk("t3_ready2", int'(alloc_ready), 1);
        drive(2'b01, 2'd0, 2'b00, 0, 0, 1'b0);
        exp_q.push_back(62);
        step();
        idle();
        chk("t3_count1", int'(count), 1);
        chk("t3_ready1", int'(alloc_ready), 0);
        drive(2'b11, 2'd0, 2'b00, 0, 0, 1'b0);
        step();
        idle();
        chk("t3_no_fire_count", int'(count), 1);
        drive(2'b00, 2'd2, 2'b11, 5, 7, 1'b0);
        #1;
        chk("t3_no_bypass_ready", int'(alloc_ready), 0);
        step();
        idle();
        chk("t3_count3", int'(count), 3);
        chk("t3_ready3", int'(alloc_ready), 1);
        drive(2'b01, 2'd0, 2'b00, 0, 0, 1'b0);
        exp_q.push_back(63);
        step();
        drive(2'b11, 2'd0, 2'b00, 0, 0, 1'b0);
        exp_q.push_back(5);
        exp_q.push_back(7);
        step();
        idle();
        chk("t3_empty_count", int'(count), 0);
        chk("t3_empty_ready", int'(alloc_ready), 0);

        // Flush with a same-cycle commit.
        do_reset();
        drive(2'b11, 2'd0, 2'b00, 0, 0, 1'b0);
        exp_q.push_back(32);
        exp_q.push_back(33);
        step();
        drive(2'b11, 2'd0, 2'b00, 0, 0, 1'b0);
        exp_q.push_back(34);
        exp_q.push_back(35);
        step();
        drive(2'b00, 2'd1, 2'b00, 0, 0, 1'b0);
        step();
        drive(2'b11, 2'd1, 2'b00, 0, 0, 1'b1);
        #1;
        chk("t4_flush_ready", int'(alloc_ready), 0);
        step();
        idle();
        chk("t4_count", int'(count), 30);
        chk("t4_next_id0", int'(alloc_id[0]), 34);
        drive(2'b01, 2'd0, 2'b00, 0, 0, 1'b0);
        exp_q.push_back(34);
        step();
        idle();

        // Reset overriding an allocation and flush in progress.
        do_reset();
        drive(2'b11, 2'd0, 2'b00, 0, 0, 1'b0);
        exp_q.push_back(32);
        exp_q.push_back(33);
        step();
        drive(2'b11, 2'd0, 2'b00, 0, 0, 1'b0);
        exp_q.push_back(34);
        exp_q.push_back(35);
        step();
        resetn = 1'b0;
        drive(2'b11, 2'd0, 2'b00, 0, 0, 1'b1);
        step();
        resetn = 1'b1;
        idle();
        chk("t5_count", int'(count), 32);
        chk("t5_id0", int'(alloc_id[0]), 32);
        chk("t5_id1", int'(alloc_id[1]), 33);
        chk("t5_ready", int'(alloc_ready), 1);

        run_random(800);

        step();
        chk("scoreboard_final", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/free_list.md
FREE_LIST -- requirements
Module: free_list

Interface
REQ-001 Parameter N_PREG, default 64, meaning: total physical registers; ids are $clog2(N_PREG) bits wide.
REQ-002 Parameter N_AREG, default 32, meaning: architectural registers; ids 0..N_AREG-1 are mapped at reset and are not free.
REQ-003 Parameter N_ALLOC, default 2, meaning: allocation lanes per cycle.
REQ-004 Parameter N_FREE, default 2, meaning: release lanes per cycle.
REQ-005 Derived DEPTH = N_PREG-N_AREG shall be a power of two; a violation shall be a static elaboration error.
REQ-006 clk  input  1  clock; the block has one clock, and all state updates on its rising edge.
REQ-007 resetn  input  1  reset; synchronous and active-low.
REQ-008 alloc_req  input  N_ALLOC  per-lane allocation request.
REQ-009 alloc_ready  output  1  allocation accepted this cycle.
REQ-010 alloc_id  output  N_ALLOC x id  allocated id per lane; valid when alloc_req[i] && alloc_ready.
REQ-011 commit_cnt  input  $clog2(N_ALLOC+1)  number of oldest outstanding allocations retired this cycle.
REQ-012 free_valid  input  N_FREE  per-lane release valid.
REQ-013 free_id  input  N_FREE x id  id being released.
REQ-014 flush  input  1  squash all uncommitted allocations.
REQ-015 count  output  $clog2(DEPTH+1)  free ids currently available to allocation.

Function
REQ-016 Storage shall be a DEPTH-entry circular queue of ids plus three pointers, each $clog2(DEPTH)+1 bits with a wrap bit: head (speculative allocation), chead (committed allocation), tail (insertion).
REQ-017 count shall equal tail-head modulo 2^(ptr width) and shall be registered.
REQ-018 alloc_ready shall be high iff count >= N_ALLOC and flush is low; it is all-or-nothing and independent of alloc_req.
REQ-019 Requesting lanes shall be compacted: lane i receives entry[head+k], where k is the number of set alloc_req bits below i.
REQ-020 alloc_id shall be combinational from registered state, with zero-cycle latency; non-requesting lanes' alloc_id is don't-care.
REQ-021 On a fire (alloc_ready && |alloc_req), head shall advance by popcount(alloc_req); otherwise head shall hold.
REQ-022 Releasing lanes shall be compacted the same way: lane j writes free_id[j] to entry[tail+k]. tail shall advance by popcount(free_valid).
REQ-023 Ids released in cycle t shall not be allocatable before cycle t+1; there is no same-cycle bypass.
REQ-024 chead shall advance by commit_cnt every cycle, including flush cycles.
REQ-025 On flush, head shall load chead+commit_cnt, and alloc_req shall be ignored that cycle. Releases and commits in the same cycle shall still take effect.
REQ-026 The following are protocol violations, flagged by a simulation-only assertion with no recovery required:
- commit_cnt exceeding head-chead;
- a release that would make tail-chead exceed DEPTH.
REQ-027 Pointer wrap-around from DEPTH-1 to 0 shall be seamless; full (count==DEPTH) and empty (count==0) shall be distinguished by the wrap bit.

Reset
REQ-028 While resetn is low at a clock edge:
- entry[k] shall be set to N_AREG+k for k in 0..DEPTH-1;
- head and chead shall be set to 0;
- tail shall be set to DEPTH with the wrap bit set.
REQ-029 After reset:
- count shall be DEPTH;
- alloc_ready shall be 1;
- alloc_id[i] shall be N_AREG+i.
REQ-030 Reset shall override all inputs, including an allocation or flush in progress.

Verification (N_PREG=64, N_AREG=32, N_ALLOC=2, N_FREE=2)
REQ-031 Reset, then alloc_req=2'b11 for one cycle -> alloc_id={33,32}, fire; next cycle count=30, alloc_id[0]=34.
REQ-032 Reset, then alloc_req=2'b10 -> lane1 gets 32, head+1. Next cycle alloc_req=2'b01 -> lane0 gets 33.
REQ-033 Allocate 30 ids with no commits -> count=2, alloc_ready=1. Allocate 1 more -> count=1, alloc_ready=0. free_valid=2'b11 with ids {5,7} -> next cycle count=3, alloc_ready=1, and 5 and 7 are allocated after id 63 in order 5, 7.
REQ-034 Allocate 4 ids (32..35), commit_cnt=1, then flush with commit_cnt=1 in the same cycle -> head=chead=2, count=30, next alloc_id[0]=34.
REQ-035 Run a long random alloc/commit/free mix with pointer wrap over more than 3 laps, checked against a reference model -> no duplicate live id, count is always in 0..32, and the set of all ids is conserved.
REQ-036 Assert resetn low mid-burst with alloc_req=2'b11 and flush=1 -> next cycle count=32, alloc_id={33,32}.
